// File: rtl/noc_run_ctrl.sv
// noc_run_ctrl: per-node traffic configuration holder and run sequencer for
// the 3x3 mesh; flushes, enables, detects completion, then folds latency stats.
module noc_run_ctrl #(
    parameter int          NODES     = 9,
    parameter int          FLUSH_CYC = 2,
    parameter logic [23:0] TIMEOUT   = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_node,
    input  logic [3:0]            cfg_send_num,
    input  logic [3:0]            cfg_recv_num,
    input  logic [3:0]            cfg_rate,
    input  logic [3:0]            cfg_mode,
    input  logic [35:0]           cfg_dst_seq,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NODES-1:0]      send_finish,
    input  logic [NODES-1:0]      recv_finish,
    input  logic [10*NODES-1:0]   lat_max_bus,
    input  logic [28*NODES-1:0]   lat_sum_bus,
    output logic [4*NODES-1:0]    send_num_bus,
    output logic [4*NODES-1:0]    recv_num_bus,
    output logic [4*NODES-1:0]    rate_bus,
    output logic [4*NODES-1:0]    mode_bus,
    output logic [36*NODES-1:0]   dst_seq_bus,
    output logic                  noc_enable,
    output logic                  noc_flush,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic [23:0]           run_cycles,
    output logic [9:0]            agg_lat_max,
    output logic [31:0]           agg_lat_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_COLLECT,
        S_DONE
    } state_t;

    localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYC - 1);
    localparam logic [3:0]  NODE_LAST  = 4'(NODES - 1);
    localparam logic [23:0] RUN_LAST   = TIMEOUT - 24'd1;

    state_t                 state_q;
    logic [NODES-1:0][3:0]  send_q;
    logic [NODES-1:0][3:0]  recv_q;
    logic [NODES-1:0][3:0]  rate_q;
    logic [NODES-1:0][3:0]  mode_q;
    logic [NODES-1:0][35:0] dst_q;
    logic [NODES-1:0][9:0]  lat_max_v;
    logic [NODES-1:0][27:0] lat_sum_v;

    logic [3:0]  fl_cnt_q;
    logic [3:0]  idx_q;
    logic        flush_q;
    logic        enable_q;
    logic        busy_q;
    logic        done_q;
    logic        timed_out_q;
    logic [23:0] run_cycles_q;
    logic [23:0] run_cycles_d;
    logic [9:0]  agg_max_q;
    logic [9:0]  node_max;
    logic [31:0] agg_sum_q;
    logic [31:0] agg_sum_d;
    logic        cfg_open;
    logic        all_fin;
    logic        hit_limit;

    assign lat_max_v = lat_max_bus;
    assign lat_sum_v = lat_sum_bus;

    assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);
    assign hit_limit = (run_cycles_q == RUN_LAST);
    assign run_cycles_d = run_cycles_q + 24'd1;
    assign node_max = lat_max_v[idx_q];
    assign agg_sum_d = agg_sum_q + {4'd0, lat_sum_v[idx_q]};

    // Per-node configuration; writes only land between runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            send_q <= '0;
            recv_q <= '0;
            rate_q <= '0;
            mode_q <= '0;
            dst_q  <= '0;
        end else if (cfg_we && cfg_open && (cfg_node <= NODE_LAST)) begin
            send_q[cfg_node] <= cfg_send_num;
            recv_q[cfg_node] <= cfg_recv_num;
            rate_q[cfg_node] <= cfg_rate;
            mode_q[cfg_node] <= cfg_mode;
            dst_q[cfg_node]  <= cfg_dst_seq;
        end
    end

    // A node counts as finished when it has nothing to do or raised its flag.
    always_comb begin
        all_fin = 1'b1;
        for (int i = 0; i < NODES; i++) begin
            if (!((send_q[i] == 4'd0) || send_finish[i]))
                all_fin = 1'b0;
            if (!((recv_q[i] == 4'd0) || recv_finish[i]))
                all_fin = 1'b0;
        end
    end

    // Run sequencer: flush, enable, completion/timeout, stat collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fl_cnt_q     <= '0;
            idx_q        <= '0;
            flush_q      <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            run_cycles_q <= '0;
            agg_max_q    <= '0;
            agg_sum_q    <= '0;
        end else if (abort) begin
            state_q  <= S_IDLE;
            flush_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_FLUSH;
                        fl_cnt_q     <= '0;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        timed_out_q  <= 1'b0;
                        run_cycles_q <= '0;
                        agg_max_q    <= '0;
                        agg_sum_q    <= '0;
                    end
                end
                S_FLUSH: begin
                    if (fl_cnt_q == FLUSH_LAST) begin
                        state_q  <= S_RUN;
                        flush_q  <= 1'b0;
                        enable_q <= 1'b1;
                    end else begin
                        fl_cnt_q <= fl_cnt_q + 4'd1;
                    end
                end
                S_RUN: begin
                    run_cycles_q <= run_cycles_d;
                    if (all_fin || hit_limit) begin
                        state_q     <= S_COLLECT;
                        enable_q    <= 1'b0;
                        idx_q       <= '0;
                        timed_out_q <= hit_limit;
                    end
                end
                S_COLLECT: begin
                    agg_sum_q <= agg_sum_d;
                    if (node_max > agg_max_q)
                        agg_max_q <= node_max;
                    if (idx_q == NODE_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign send_num_bus = send_q;
    assign recv_num_bus = recv_q;
    assign rate_bus     = rate_q;
    assign mode_bus     = mode_q;
    assign dst_seq_bus  = dst_q;
    assign noc_enable   = enable_q;
    assign noc_flush    = flush_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timed_out    = timed_out_q;
    assign run_cycles   = run_cycles_q;
    assign agg_lat_max  = agg_max_q;
    assign agg_lat_sum  = agg_sum_q;

endmodule

// File: tb/tb_noc_run_ctrl.sv
// tb_noc_run_ctrl: randomized runs of noc_run_ctrl against a run-timeline model,
// plus hotspot, aggregation, guard, abort and timeout scenarios.
module tb_noc_run_ctrl;

    localparam int FLUSH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [3:0]    cfg_node;
    logic [3:0]    cfg_send_num;
    logic [3:0]    cfg_recv_num;
    logic [3:0]    cfg_rate;
    logic [3:0]    cfg_mode;
    logic [35:0]   cfg_dst_seq;
    logic          start;
    logic          abort;
    logic [8:0]    send_finish;
    logic [8:0]    recv_finish;
    logic [89:0]   lat_max_bus;
    logic [251:0]  lat_sum_bus;

    logic [35:0]   send_num_bus, recv_num_bus, rate_bus, mode_bus;
    logic [323:0]  dst_seq_bus;
    logic          noc_enable, noc_flush, busy, done, timed_out;
    logic [23:0]   run_cycles;
    logic [9:0]    agg_lat_max;
    logic [31:0]   agg_lat_sum;

    logic [35:0]   to_send, to_recv, to_rate, to_mode;
    logic [323:0]  to_dst;
    logic          to_noc_enable, to_noc_flush, to_busy, to_done, to_timed_out;
    logic [23:0]   to_run_cycles;
    logic [9:0]    to_agg_max;
    logic [31:0]   to_agg_sum;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0]  m_send [9];
    logic [3:0]  m_recv [9];
    logic [3:0]  m_rate [9];
    logic [3:0]  m_mode [9];
    logic [35:0] m_dst  [9];

    always #5 clk = ~clk;

    noc_run_ctrl #(.NODES(9), .FLUSH_CYC(FLUSH), .TIMEOUT(24'hFFFFFF)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_node(cfg_node),
        .cfg_send_num(cfg_send_num), .cfg_recv_num(cfg_recv_num),
        .cfg_rate(cfg_rate), .cfg_mode(cfg_mode), .cfg_dst_seq(cfg_dst_seq),
        .start(start), .abort(abort),
        .send_finish(send_finish), .recv_finish(recv_finish),
        .lat_max_bus(lat_max_bus), .lat_sum_bus(lat_sum_bus),
        .send_num_bus(send_num_bus), .recv_num_bus(recv_num_bus),
        .rate_bus(rate_bus), .mode_bus(mode_bus), .dst_seq_bus(dst_seq_bus),
        .noc_enable(noc_enable), .noc_flush(noc_flush), .busy(busy),
        .done(done), .timed_out(timed_out), .run_cycles(run_cycles),
        .agg_lat_max(agg_lat_max), .agg_lat_sum(agg_lat_sum)
    );

    noc_run_ctrl #(.NODES(9), .FLUSH_CYC(FLUSH), .TIMEOUT(24'd16)) u_dut_to (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_node(cfg_node),
        .cfg_send_num(cfg_send_num), .cfg_recv_num(cfg_recv_num),
        .cfg_rate(cfg_rate), .cfg_mode(cfg_mode), .cfg_dst_seq(cfg_dst_seq),
        .start(start), .abort(abort),
        .send_finish(send_finish), .recv_finish(recv_finish),
        .lat_max_bus(lat_max_bus), .lat_sum_bus(lat_sum_bus),
        .send_num_bus(to_send), .recv_num_bus(to_recv),
        .rate_bus(to_rate), .mode_bus(to_mode), .dst_seq_bus(to_dst),
        .noc_enable(to_noc_enable), .noc_flush(to_noc_flush), .busy(to_busy),
        .done(to_done), .timed_out(to_timed_out), .run_cycles(to_run_cycles),
        .agg_lat_max(to_agg_max), .agg_lat_sum(to_agg_sum)
    );

    task automatic chk(input string tag, input logic [323:0] got,
                       input logic [323:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] pack4(input logic [3:0] a [9]);
        logic [35:0] v;
        for (int i = 0; i < 9; i++) v[4*i +: 4] = a[i];
        return v;
    endfunction

    function automatic logic [323:0] pack_dst();
        logic [323:0] v;
        for (int i = 0; i < 9; i++) v[36*i +: 36] = m_dst[i];
        return v;
    endfunction

    // A run may end once every node has either no work or its flag raised.
    function automatic bit model_fin(input logic [8:0] sf, input logic [8:0] rf);
        bit ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (m_send[i] != 4'd0 && !sf[i]) ok = 1'b0;
            if (m_recv[i] != 4'd0 && !rf[i]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endfunction

    task automatic chk_cfg(input string tag);
        chk({tag, "_send"}, send_num_bus, pack4(m_send));
        chk({tag, "_recv"}, recv_num_bus, pack4(m_recv));
        chk({tag, "_rate"}, rate_bus, pack4(m_rate));
        chk({tag, "_mode"}, mode_bus, pack4(m_mode));
        chk({tag, "_dst"}, dst_seq_bus, pack_dst());
    endtask

    task automatic cfg_write(input int n, input logic [3:0] s, input logic [3:0] r,
                             input logic [3:0] ra, input logic [3:0] mo,
                             input logic [35:0] d);
        cfg_we = 1'b1;
        cfg_node = 4'(n);
        cfg_send_num = s;
        cfg_recv_num = r;
        cfg_rate = ra;
        cfg_mode = mo;
        cfg_dst_seq = d;
        step();
        cfg_we = 1'b0;
        if (n < 9) begin
            m_send[n] = s;
            m_recv[n] = r;
            m_rate[n] = ra;
            m_mode[n] = mo;
            m_dst[n]  = d;
        end
        chk_cfg("cfg");
    endtask

    task automatic run_one(input int fin_k, input bit rnd_flags,
                           input bit noise, input bit fixed_agg);
        int k;
        bit fin;
        logic [8:0] sf, rf;
        logic [9:0] emax, nm;
        logic [31:0] esum;
        logic [27:0] ns;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int f = 1; f <= FLUSH; f++) begin
            chk("flush_hi", noc_flush, 1);
            chk("flush_en_lo", noc_enable, 0);
            chk("flush_busy", busy, 1);
            chk("flush_done_lo", done, 0);
            if (f == 1) begin
                chk("clr_rc", run_cycles, 0);
                chk("clr_max", agg_lat_max, 0);
                chk("clr_sum", agg_lat_sum, 0);
                chk("clr_to", timed_out, 0);
            end
            step();
        end
        k = 0;
        fin = 1'b0;
        while (!fin && k < 200) begin
            k++;
            chk("run_en", noc_enable, 1);
            chk("run_flush_lo", noc_flush, 0);
            chk("run_rc", run_cycles, 24'(k - 1));
            if (k >= fin_k) {sf, rf} = '1;
            else if (rnd_flags) {sf, rf} = 18'($urandom);
            else {sf, rf} = '0;
            send_finish = sf;
            recv_finish = rf;
            fin = model_fin(sf, rf);
            if (noise) begin
                cfg_we = 1'($urandom);
                cfg_node = 4'($urandom);
                cfg_send_num = 4'($urandom);
                cfg_recv_num = 4'($urandom);
                cfg_rate = 4'($urandom);
                cfg_mode = 4'($urandom);
                cfg_dst_seq = {4'($urandom), $urandom};
                start = 1'($urandom);
            end
            step();
        end
        chk("run_model_ended", fin, 1);
        cfg_we = 1'b0;
        start = 1'b0;
        send_finish = '0;
        recv_finish = '0;
        chk("end_en_lo", noc_enable, 0);
        chk("end_rc", run_cycles, 24'(k));
        chk("end_busy", busy, 1);
        emax = '0;
        esum = '0;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < 9; i++) begin
                lat_max_bus[10*i +: 10] = fixed_agg ? 10'(10*i + 3) : 10'($urandom);
                lat_sum_bus[28*i +: 28] = fixed_agg ? 28'(100*i) : 28'($urandom);
            end
            nm = lat_max_bus[10*c +: 10];
            ns = lat_sum_bus[28*c +: 28];
            if (nm > emax) emax = nm;
            esum = esum + 32'(ns);
            chk("collect_done_lo", done, 0);
            step();
        end
        chk("done_hi", done, 1);
        chk("done_busy_lo", busy, 0);
        chk("done_to_lo", timed_out, 0);
        chk("agg_max", agg_lat_max, emax);
        chk("agg_sum", agg_lat_sum, esum);
        if (fixed_agg) begin
            chk("agg_max_fixed", agg_lat_max, 83);
            chk("agg_sum_fixed", agg_lat_sum, 3600);
        end
        chk_cfg("run_guard");
        step();
        chk("hold_done", done, 1);
        chk("hold_rc", run_cycles, 24'(k));
        chk("hold_sum", agg_lat_sum, esum);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_cnt, fall_at, done_at;
        bit seen;
        for (int i = 0; i < 9; i++) begin
            m_send[i] = '0; m_recv[i] = '0; m_rate[i] = '0;
            m_mode[i] = '0; m_dst[i] = '0;
        end
        rst = 1'b1; cfg_we = 1'b0; cfg_node = '0; cfg_send_num = '0;
        cfg_recv_num = '0; cfg_rate = '0; cfg_mode = '0; cfg_dst_seq = '0;
        start = 1'b0; abort = 1'b0; send_finish = '0; recv_finish = '0;
        lat_max_bus = '0; lat_sum_bus = '0;

        step();
        step();
        chk("rst_en", noc_enable, 0);
        chk("rst_flush", noc_flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_to", timed_out, 0);
        chk("rst_rc", run_cycles, 0);
        chk("rst_max", agg_lat_max, 0);
        chk("rst_sum", agg_lat_sum, 0);
        chk_cfg("rst");
        chk("rst_to_busy", to_busy, 0);
        rst = 1'b0;
        step();

        // all-idle configuration: exactly one RUN cycle
        run_one(1000, 1'b0, 1'b0, 1'b0);
        chk("idle_rc1", run_cycles, 1);

        // hotspot: node 11 (index 4) sinks everything
        for (int i = 0; i < 9; i++) begin
            if (i == 4) cfg_write(i, 4'd0, 4'd8, 4'd0, 4'd1, 36'h0_1234_9785);
            else cfg_write(i, 4'd1, 4'd1, 4'd0, 4'd1, {4'($urandom), $urandom});
        end
        cfg_write(9, 4'hF, 4'hF, 4'hF, 4'hF, '1);
        run_one(38, 1'b0, 1'b0, 1'b1);

        // abort from DONE, then abort together with start in IDLE
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_lo", done, 0);
        chk("abort_busy_lo", busy, 0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abst_flush", noc_flush, 0);
        chk("abst_busy", busy, 0);
        step();
        chk("abst_flush2", noc_flush, 0);
        chk("abst_en2", noc_enable, 0);

        // abort in the middle of RUN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int c = 0; c < 5; c++) step();
        chk("pre_abort_en", noc_enable, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("mid_abort_en", noc_enable, 0);
        chk("mid_abort_flush", noc_flush, 0);
        chk("mid_abort_done", done, 0);
        chk("mid_abort_busy", busy, 0);
        chk("mid_abort_rc", run_cycles, 5);
        run_one($urandom_range(1, 20), 1'b1, 1'b0, 1'b0);

        // randomized configurations and runs with guard noise
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 5; w++)
                cfg_write($urandom_range(0, 11), rnib(), rnib(), 4'($urandom),
                          4'($urandom), {4'($urandom), $urandom});
            run_one($urandom_range(1, 30), 1'b1, 1'b1, r[0]);
        end

        // timeout on the short-limit instance
        abort = 1'b1;
        step();
        abort = 1'b0;
        cfg_write(0, 4'd1, 4'd1, 4'd0, 4'd0, '0);
        send_finish = '0;
        recv_finish = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        en_cnt = 0;
        fall_at = -1;
        done_at = -1;
        seen = 1'b0;
        for (int c = 0; c < 120 && done_at < 0; c++) begin
            if (to_noc_enable) begin
                en_cnt++;
                seen = 1'b1;
            end else if (seen && fall_at < 0) begin
                fall_at = c;
            end
            if (to_done) done_at = c;
            step();
        end
        chk("to_done_seen", done_at >= 0, 1);
        chk("to_en_cycles", en_cnt, 16);
        chk("to_flag", to_timed_out, 1);
        chk("to_rc", to_run_cycles, 16);
        chk("to_done_gap", done_at - fall_at, 9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
